// File: rtl/ntt_sched_pkg.sv
// ntt_sched_pkg: mode codes, state encoding and default sizing shared by the NTT
// phase sequencer, its address generator and the host wrapper.
package ntt_sched_pkg;

  localparam int N_LAYERS_DEF    = 8;
  localparam int LAYER_W_DEF     = 4;
  localparam int IO_CYCLES_DEF   = 516;
  localparam int CYC_W_DEF       = 12;
  localparam int WDOG_CYCLES_DEF = 4096;

  typedef enum logic [1:0] {
    MODE_NTT  = 2'b00,
    MODE_INTT = 2'b01,
    MODE_IN   = 2'b10,
    MODE_OUT  = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_UNLOAD = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  function automatic mode_t run_mode(input logic inv);
    if (inv) begin
      return MODE_INTT;
    end else begin
      return MODE_NTT;
    end
  endfunction

endpackage

// File: rtl/ntt_sched_ctrl_if.sv
// ntt_sched_ctrl_if: host/generator handshake bundle of the NTT phase sequencer.
// master = host wrapper + generator side, slave = the sequencer.
interface ntt_sched_ctrl_if #(
  parameter int LAYER_W = ntt_sched_pkg::LAYER_W_DEF
);
  import ntt_sched_pkg::*;

  logic               start;
  logic               inv;
  logic               abort;
  logic               ag_done;
  mode_t              mode;
  logic               newloop;
  logic [LAYER_W-1:0] layer;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, inv, abort, ag_done,
    input  mode, newloop, layer, busy, done, err
  );

  modport slave (
    input  start, inv, abort, ag_done,
    output mode, newloop, layer, busy, done, err
  );

endinterface

// File: rtl/sched_cycle_cnt.sv
// sched_cycle_cnt: clearable, enabled, saturating cycle counter with a terminal-count
// flag against a run-time limit; times IN/OUT phases and the per-layer watchdog.
module sched_cycle_cnt #(
  parameter int CYC_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CYC_W-1:0] limit,
  output logic             tc
);

  logic [CYC_W-1:0] cnt_r;

  assign tc = (cnt_r >= limit);

  // counter register: clear wins, then count up and stop at the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CYC_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CYC_W{1'b0}};
    end else if (en && !tc) begin
      cnt_r <= cnt_r + {{(CYC_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/ntt_sched_ctrl.sv
// ntt_sched_ctrl: sequences the NTT address generator through IN, N_LAYERS butterfly
// layers and OUT per transform. Optional layer watchdog / ERR state: SCHED_WDOG_EN.
module ntt_sched_ctrl
  import ntt_sched_pkg::*;
#(
  parameter int N_LAYERS    = N_LAYERS_DEF,
  parameter int LAYER_W     = LAYER_W_DEF,
  parameter int IO_CYCLES   = IO_CYCLES_DEF,
  parameter int CYC_W       = CYC_W_DEF,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ntt_sched_ctrl_if.slave bus
);

  localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(N_LAYERS - 32'sd1);
  localparam logic [CYC_W-1:0]   IO_LAST    = CYC_W'(IO_CYCLES - 32'sd1);
  localparam logic [CYC_W-1:0]   WDOG_LAST  = CYC_W'(WDOG_CYCLES - 32'sd1);

  state_t             state_r, state_s;
  mode_t              mode_r, mode_s;
  logic               newloop_r, newloop_s;
  logic [LAYER_W-1:0] layer_r, layer_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               err_r, err_s;
  logic               inv_q_r, inv_q_s;

  logic               cyc_tc_s;
  logic               cnt_en_s;
  logic [CYC_W-1:0]   cnt_limit_s;
  logic               active_s;
  logic               ag_qual_s;
  logic               last_layer_s;
  logic               abort_go_s;
  logic               start_go_s;
  logic               load_end_s;
  logic               layer_adv_s;
  logic               run_end_s;
  logic               unload_end_s;
  logic               wdog_trip_s;

  assign active_s     = (state_r == ST_LOAD) || (state_r == ST_RUN) || (state_r == ST_UNLOAD);
  // the generator drops ctr_sig one edge after newloop, so the flag is stale in that cycle
  assign ag_qual_s    = bus.ag_done && !newloop_r;
  assign last_layer_s = (layer_r == LAST_LAYER);
  assign abort_go_s   = bus.abort && active_s;

`ifdef SCHED_WDOG_EN
  assign start_go_s  = bus.start && !bus.abort && ((state_r == ST_IDLE) || (state_r == ST_ERR));
  assign wdog_trip_s = (state_r == ST_RUN) && cyc_tc_s && !ag_qual_s;
  assign cnt_en_s    = active_s;
`else
  assign start_go_s  = bus.start && !bus.abort && (state_r == ST_IDLE);
  assign wdog_trip_s = 1'b0;
  assign cnt_en_s    = (state_r == ST_LOAD) || (state_r == ST_UNLOAD);
`endif

  assign load_end_s   = (state_r == ST_LOAD) && cyc_tc_s;
  assign layer_adv_s  = (state_r == ST_RUN) && ag_qual_s && !last_layer_s;
  assign run_end_s    = (state_r == ST_RUN) && ag_qual_s && last_layer_s;
  assign unload_end_s = (state_r == ST_UNLOAD) && cyc_tc_s;
  assign cnt_limit_s  = (state_r == ST_RUN) ? WDOG_LAST : IO_LAST;

  // every newloop restarts the phase/watchdog count
  sched_cycle_cnt #(
    .CYC_W (CYC_W)
  ) u_cyc (
    .clk   (clk),
    .rst   (rst),
    .clr   (newloop_s),
    .en    (cnt_en_s),
    .limit (cnt_limit_s),
    .tc    (cyc_tc_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_go_s) state_s = ST_LOAD;
        else            state_s = ST_IDLE;
      end
      ST_LOAD: begin
        if (abort_go_s)      state_s = ST_IDLE;
        else if (load_end_s) state_s = ST_RUN;
        else                 state_s = ST_LOAD;
      end
      ST_RUN: begin
        if (abort_go_s)       state_s = ST_IDLE;
        else if (run_end_s)   state_s = ST_UNLOAD;
        else if (wdog_trip_s) state_s = ST_ERR;
        else                  state_s = ST_RUN;
      end
      ST_UNLOAD: begin
        if (abort_go_s || unload_end_s) state_s = ST_IDLE;
        else                            state_s = ST_UNLOAD;
      end
      ST_ERR: begin
`ifdef SCHED_WDOG_EN
        if (start_go_s) state_s = ST_LOAD;
        else            state_s = ST_ERR;
`else
        state_s = ST_IDLE;
`endif
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs, one event per cycle
  always_comb begin
    mode_s    = mode_r;
    newloop_s = 1'b0;
    layer_s   = layer_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    err_s     = err_r;
    inv_q_s   = inv_q_r;
    if (abort_go_s) begin
      mode_s    = MODE_IN;
      newloop_s = 1'b1;
      layer_s   = {LAYER_W{1'b0}};
      busy_s    = 1'b0;
    end else if (start_go_s) begin
      mode_s    = MODE_IN;
      newloop_s = 1'b1;
      busy_s    = 1'b1;
      err_s     = 1'b0;
      inv_q_s   = bus.inv;
    end else if (load_end_s) begin
      mode_s    = run_mode(inv_q_r);
      newloop_s = 1'b1;
      layer_s   = {LAYER_W{1'b0}};
    end else if (layer_adv_s) begin
      newloop_s = 1'b1;
      layer_s   = layer_r + {{(LAYER_W-1){1'b0}}, 1'b1};
    end else if (run_end_s) begin
      mode_s    = MODE_OUT;
      newloop_s = 1'b1;
    end else if (unload_end_s) begin
      done_s    = 1'b1;
      busy_s    = 1'b0;
    end else if (wdog_trip_s) begin
      mode_s    = MODE_IN;
      newloop_s = 1'b1;
      busy_s    = 1'b0;
      err_s     = 1'b1;
    end else begin
      newloop_s = 1'b0;
      done_s    = 1'b0;
    end
  end

  // output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r    <= MODE_IN;
      newloop_r <= 1'b0;
      layer_r   <= {LAYER_W{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      inv_q_r   <= 1'b0;
    end else begin
      mode_r    <= mode_s;
      newloop_r <= newloop_s;
      layer_r   <= layer_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      err_r     <= err_s;
      inv_q_r   <= inv_q_s;
    end
  end

  assign bus.mode    = mode_r;
  assign bus.newloop = newloop_r;
  assign bus.layer   = layer_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.err     = err_r;

endmodule
